// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit core: opcodes, NOP encoding
// and the fetch-stage next-state action.
package cpu_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_PCS = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [15:0] INSTR_NOP = 16'h0000;

    typedef enum logic [1:0] {
        FETCH_HOLD,
        FETCH_REDIRECT,
        FETCH_ADVANCE,
        FETCH_HALT
    } fetch_action_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+2 and valid bit with
// flush (squash to bubble) taking priority over hold.
module if_id_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic [DATA_W-1:0] next_instr,
    input  logic [DATA_W-1:0] next_pc_plus2,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pc_plus2,
    output logic              valid
);
    import cpu_pkg::*;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= DATA_W'(INSTR_NOP);
            pc_plus2 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= DATA_W'(INSTR_NOP);
            pc_plus2 <= '0;
            valid    <= 1'b0;
        end else if (!hold) begin
            instr    <= next_instr;
            pc_plus2 <= next_pc_plus2;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, incrementer, redirect/stall/halt priority
// and the IF/ID register feeding decode.
module fetch_stage #(
    parameter int              DATA_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [DATA_W-1:0] ifid_pc_plus2,
    output logic              ifid_valid,
    output logic              halted
);
    import cpu_pkg::*;

    fetch_action_e     action;
    logic [DATA_W-1:0] pc_plus2;
    logic [DATA_W-1:0] redirect_pc;
    logic              is_hlt;

    assign imem_addr   = pc;
    assign pc_plus2    = pc + DATA_W'(2);
    assign redirect_pc = branch_target & ~DATA_W'(1);
    assign is_hlt      = (imem_data[DATA_W-1 -: 4] == OP_HLT);

    // Halt dominates everything; a HLT only counts when it would really be fetched.
    always_comb begin
        action = FETCH_ADVANCE;
        if (halted)
            action = FETCH_HOLD;
        else if (branch_taken)
            action = FETCH_REDIRECT;
        else if (stall)
            action = FETCH_HOLD;
        else if (is_hlt)
            action = FETCH_HALT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else begin
            case (action)
                FETCH_REDIRECT: pc <= redirect_pc;
                FETCH_ADVANCE:  pc <= pc_plus2;
                FETCH_HALT:     halted <= 1'b1;
                default:        ;
            endcase
        end
    end

    if_id_reg #(
        .DATA_W(DATA_W)
    ) u_if_id (
        .clk          (clk),
        .rst          (rst),
        .hold         (action == FETCH_HOLD),
        .flush        (action == FETCH_REDIRECT),
        .next_instr   (imem_data),
        .next_pc_plus2(pc_plus2),
        .instr        (ifid_instr),
        .pc_plus2     (ifid_pc_plus2),
        .valid        (ifid_valid)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit core. It feeds the control decoder's opcode and the rest of decode.
- Owns the PC and drives the instruction-memory address.
- Handles stall hold, taken-branch redirect and flush, and HLT detection.
- Branches resolve in ID. Branch target and taken come back from decode and take effect on the next clock edge.

Parameters:
- DATA_W, 16: instruction and PC width.
- RESET_PC, 16'h0000: PC value loaded on reset.

Ports:
- clk, input, 1: core clock, rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- stall, input, 1: hazard-unit hold request for PC and IF/ID.
- branch_taken, input, 1: decode has resolved a taken B/BR this cycle.
- branch_target, input, DATA_W: redirect address; bit 0 is ignored (forced 0).
- imem_addr, output, DATA_W: instruction-memory address; equals pc.
- imem_data, input, DATA_W: instruction read combinationally at imem_addr in the same cycle.
- pc, output, DATA_W: current fetch PC.
- ifid_instr, output, DATA_W: latched instruction to decode.
- ifid_pc_plus2, output, DATA_W: latched fetch PC + 2, used by PCS and B target math.
- ifid_valid, output, 1: ifid_instr is a real instruction; 0 means bubble.
- halted, output, 1: HLT captured into IF/ID; sticky.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC, ifid_instr = NOP (16'h0000), ifid_pc_plus2 = 0, ifid_valid = 0, halted = 0.
  - Applies mid-operation too; all state is discarded.
- Next-state priority at each rising edge:
  1. halted = 1: pc and IF/ID hold; stall and branch_taken are ignored. Stays until rst.
  2. branch_taken = 1: pc <= {branch_target[15:1],1'b0}; ifid_instr <= NOP; ifid_valid <= 0; ifid_pc_plus2 <= 0. The in-flight fetch is squashed. Overrides a simultaneous stall.
  3. stall = 1: pc and all IF/ID fields hold their values.
  4. Normal: pc <= pc + 2; ifid_instr <= imem_data; ifid_pc_plus2 <= pc + 2; ifid_valid <= 1.
- HLT detection (opcode imem_data[15:12] == 4'b1111):
  - Only in the normal case (no halted, no branch_taken, no stall).
  - IF/ID captures the HLT with valid = 1, halted <= 1, and pc <= pc, not pc + 2. PC stays pointing at the HLT.
  - A HLT fetched under branch_taken or stall never sets halted.
- Arithmetic:
  - pc + 2 is modulo 2^16; 16'hFFFE wraps to 16'h0000, no flag.
  - pc[0] is always 0.
- Latency: one cycle from a fetch address to ifid_instr. Redirect costs exactly one bubble.
- imem_addr = pc, combinational, no registering.

Decomposition:
- Shared package (cpu_pkg):
  - Opcode constants OP_B = 4'b1100, OP_BR = 4'b1101, OP_PCS = 4'b1110, OP_HLT = 4'b1111.
  - INSTR_NOP = 16'h0000; DATA_W.
- One sub-module: if_id_reg. Holds instr, pc_plus2 and valid, with hold (stall) and flush (branch) controls and async reset.
- fetch_stage keeps the PC register, the incrementer, the priority mux and the halt flag.

Test Plan:
- Reset then free-run, imem returns 16'h1234 everywhere:
  - pc goes 0, 2, 4, 6.
  - ifid_instr = 16'h1234 with valid = 1 from cycle 1.
  - ifid_pc_plus2 goes 2, 4, 6.
- stall for 3 cycles at pc = 16'h0008: pc stays 8 and IF/ID is unchanged; the cycle after release, pc = 16'h000A.
- branch_taken with branch_target = 16'h0041 while stall = 1: next pc = 16'h0040; ifid_valid = 0; ifid_instr = 16'h0000.
- HLT at 16'h0010 (imem_data = 16'hF000): halted = 1 one edge later and pc stays 16'h0010; later branch_taken to 16'h0100 and stall pulses leave pc at 16'h0010.
- HLT fetched in the same cycle as branch_taken to 16'h0020: halted stays 0 and pc = 16'h0020.
- pc = 16'hFFFE, normal fetch: next pc = 16'h0000 and ifid_pc_plus2 = 16'h0000.
- Assert rst asynchronously mid-stream: outputs reach reset values before the next clk edge.
